// File: rtl/ffa_rr_arbiter.sv
// ffa_rr_arbiter
//   Round-robin arbiter and sequencer that shares one modular field adder
//   (a+b mod 2^255-19) among NREQ requesters. It grants one requester at a
//   time, drives the adder, and returns the result to the requester that
//   issued it. A watchdog bounds the wait for the adder's valid, so a missing
//   valid cannot hang the fabric.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   req_i           per-requester request level (held until own gnt pulse)
//   req_a_i/req_b_i packed operands, slice i = [i*W +: W]
//   gnt_o           one-hot pulse: operands of requester i consumed
//   rsp_valid_o     one-hot pulse: rsp_data_o belongs to requester i
//   rsp_data_o      shared result register, held until the next response
//   rsp_err_o       pulse with rsp_valid_o when the watchdog expired (data 0)
//   busy_o          high whenever the sequencer is not idle
//   add_start_o     adder start strobe
//   add_a_o/add_b_o registered adder operands
//   add_result_i    adder result
//   add_valid_i     adder valid, nominally one cycle after add_start_o
module ffa_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 255,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*W-1:0] req_a_i,
    input  logic [NREQ*W-1:0] req_b_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [NREQ-1:0]   rsp_valid_o,
    output logic [W-1:0]      rsp_data_o,
    output logic              rsp_err_o,
    output logic              busy_o,
    output logic              add_start_o,
    output logic [W-1:0]      add_a_o,
    output logic [W-1:0]      add_b_o,
    input  logic [W-1:0]      add_result_i,
    input  logic              add_valid_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q;
    logic [CW-1:0]   wd_q, wd_d;
    logic [NREQ-1:0] gnt_q, rsp_valid_q;
    logic [W-1:0]    rsp_data_q, add_a_q, add_b_q;
    logic            rsp_err_q, add_start_q;

    logic [IW-1:0]   sel;
    logic            sel_vld;
    logic [IW:0]     scan;

    // Round-robin scan: first set request starting at ptr_q, wrapping at NREQ.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        scan    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr_q} + (IW+1)'(k);
            if (scan >= (IW+1)'(NREQ))
                scan = scan - (IW+1)'(NREQ);
            if (!sel_vld && req_i[scan[IW-1:0]]) begin
                sel_vld = 1'b1;
                sel     = scan[IW-1:0];
            end
        end
    end

    // Priority moves just past the requester that was served last.
    assign ptr_d = (owner_q == IW'(NREQ-1)) ? '0 : owner_q + 1'b1;
    assign wd_d  = wd_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            wd_q        <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            add_start_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
        end else begin
            // Strobes default low so each lasts exactly one cycle.
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            add_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel_vld) begin
                        owner_q     <= sel;
                        add_a_q     <= req_a_i[int'(sel)*W +: W];
                        add_b_q     <= req_b_i[int'(sel)*W +: W];
                        gnt_q       <= NREQ'(1) << sel;
                        add_start_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_q    <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A valid arriving in the expiry cycle still wins.
                    if (add_valid_i) begin
                        rsp_data_q  <= add_result_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= NREQ'(1) << owner_q;
                        state_q     <= RESP;
                    end else if (wd_d == CW'(TIMEOUT)) begin
                        // TIMEOUT cycles spent in WAIT without a valid.
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= NREQ'(1) << owner_q;
                        state_q     <= RESP;
                    end else begin
                        wd_q <= wd_d;
                    end
                end
                RESP: begin
                    ptr_q     <= ptr_d;
                    rsp_err_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = (state_q != IDLE);
    assign add_start_o = add_start_q;
    assign add_a_o     = add_a_q;
    assign add_b_o     = add_b_q;

endmodule

// File: doc/ffa_rr_arbiter.md
Name: ffa_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one modular field adder (a+b mod P, P = 2^255-19) among NREQ requesters.
- Sits between point-arithmetic engines (doubling/addition sequencers) and a single adder instance.
- Drives the adder's start/a/b ports and captures its result and valid signals.
- Returns each result to the requester that issued it.
- Includes a watchdog so that a missing adder valid never hangs the fabric.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 255, operand/result width.
- TIMEOUT, 15, maximum cycles to wait for adder valid after start before aborting.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level; held high with operands stable until own gnt bit pulses.
- req_a  in  NREQ*W  packed operand a; slice i = bits [i*W +: W].
- req_b  in  NREQ*W  packed operand b, same packing.
- gnt  out  NREQ  one-hot, one-cycle pulse: operands of requester i consumed.
- rsp_valid  out  NREQ  one-hot, one-cycle pulse: rsp_data belongs to requester i.
- rsp_data  out  W  result register, shared by all requesters.
- rsp_err  out  1  one-cycle pulse together with rsp_valid when the watchdog expired; rsp_data is then 0.
- busy  out  1  high whenever state is not IDLE.
- add_start  out  1  adder start strobe.
- add_a  out  W  adder operand a, registered.
- add_b  out  W  adder operand b, registered.
- add_result  in  W  adder result.
- add_valid  in  1  adder valid; high exactly one cycle after add_start under normal operation.

Behaviour:
- Reset values: gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, add_start=0, add_a=0, add_b=0.
- Reset values, internal: state=IDLE, round-robin pointer ptr=0, owner=0, watchdog count=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req is nonzero, select the first set bit scanning ptr, ptr+1, ... modulo NREQ.
  - Latch that requester's a/b into add_a/add_b and its index into owner.
  - Go to ISSUE. If req is zero, stay in IDLE.
- ISSUE (1 cycle):
  - add_start=1 and gnt[owner]=1.
  - Clear the watchdog and go to WAIT.
- WAIT:
  - add_start=0. The watchdog increments each cycle.
  - If add_valid: capture add_result into rsp_data, set rsp_err=0, go to RESP.
  - Else, if the watchdog reaches TIMEOUT: rsp_data=0, set an error flag, go to RESP.
- RESP (1 cycle):
  - rsp_valid[owner]=1; rsp_err = error flag.
  - ptr = (owner+1) mod NREQ; clear the error flag; go to IDLE.
- Nominal latency from req sampled in IDLE (cycle 0):
  - gnt and add_start in cycle 1.
  - add_valid in cycle 2.
  - rsp_valid in cycle 3.
  - Next grant no earlier than cycle 5 (one IDLE cycle between operations).
- Requests are sampled only in IDLE. A requester may deassert req in the cycle after its gnt, or keep it high to re-request.
- If a requester keeps req high after gnt, it is not re-granted until after RESP. Fairness still holds because ptr advances past owner.
- A req bit dropped before its gnt is simply not served. No state is held per requester.
- add_valid seen in IDLE, ISSUE or RESP is ignored (spurious).
- If add_valid and watchdog expiry occur in the same WAIT cycle, add_valid wins: normal result, no error.
- ptr wraps from NREQ-1 to 0. The round-robin scan wraps the same way.
- Reset asserted mid-operation: all outputs drop immediately to reset values and the FSM returns to IDLE. The in-flight operation is lost and no rsp_valid is issued for it.
- gnt, rsp_valid and add_start are each high for exactly one cycle per operation.
- rsp_data holds its value until the next RESP.

Test Plan:
- Single requester:
  - Stimulus: req=0001, a=5, b=7.
  - Required: gnt[0] in cycle 1; rsp_valid[0] in cycle 3 with rsp_data=12; rsp_err=0.
- Modular wrap:
  - Stimulus: requester 2 with a=P-1, b=3.
  - Required: rsp_data=2.
  - Stimulus: a=P-1, b=1.
  - Required: rsp_data=0.
- Round-robin:
  - Stimulus: req=1111 held continuously.
  - Required: grant order 0,1,2,3,0; each rsp_valid one-hot to the matching index; ptr wrap observed.
- Contention fairness:
  - Stimulus: requester 0 re-requests continuously; requester 1 asserts once after requester 0's first grant.
  - Required: requester 1 is granted next, before requester 0 is granted again.
- Watchdog:
  - Stimulus: adder model suppresses add_valid.
  - Required: rsp_valid[owner] and rsp_err=1 exactly TIMEOUT cycles into WAIT; rsp_data=0; next request then served normally.
- Reset mid-op:
  - Stimulus: assert rst in the WAIT cycle.
  - Required: busy=0 and all outputs 0 immediately; no rsp_valid pulse; post-reset req=0100 is served first (ptr=0 scan finds 2).
